// File: rtl/systolic_feeder_2x2_if.sv
// Operand/handshake bundle between a host and the 2x2 systolic feeder.
// The master side supplies the start request and matrix elements; the
// slave side (the feeder) returns status and the skewed wavefront beats.
interface systolic_feeder_2x2_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] a11, a12, a21, a22;
  logic [DATA_W-1:0] b11, b12, b21, b22;
  logic              busy;
  logic              done;
  logic              load_out;
  logic [DATA_W-1:0] row_out_row0, row_out_row1;
  logic [DATA_W-1:0] col_out_col0, col_out_col1;

  modport master (
    output start, a11, a12, a21, a22, b11, b12, b21, b22,
    input  busy, done, load_out,
    input  row_out_row0, row_out_row1, col_out_col0, col_out_col1
  );

  modport slave (
    input  start, a11, a12, a21, a22, b11, b12, b21, b22,
    output busy, done, load_out,
    output row_out_row0, row_out_row1, col_out_col0, col_out_col1
  );
endinterface

// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer for a 2x2 systolic array. Captures matrices A and B on
// start, emits four skewed wavefront beats BEAT_PERIOD cycles apart, waits
// DRAIN_CYCLES for the array to settle, then pulses done. A start seen in
// the done cycle chains straight into the next sequence.
module systolic_feeder_2x2 #(
  parameter int DATA_W       = 32,
  parameter int BEAT_PERIOD  = 16,
  parameter int DRAIN_CYCLES = 100
) (
  input logic                 clk,
  input logic                 rst,
  systolic_feeder_2x2_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Timers count down to zero, so they load one less than the interval.
  // The gap interval itself is one cycle shorter than the beat period.
  localparam logic [7:0]  GAP_RELOAD   = 8'(BEAT_PERIOD - 2);
  localparam logic [15:0] DRAIN_RELOAD = 16'(DRAIN_CYCLES - 1);

  // Operand order in each packed array: [0]=x11 [1]=x12 [2]=x21 [3]=x22
  state_e                  state_q, state_d;
  logic [1:0]              beat_q, beat_d;
  logic [7:0]              gap_tmr_q, gap_tmr_d;
  logic [15:0]             drain_tmr_q, drain_tmr_d;
  logic [3:0][DATA_W-1:0]  opa_q, opa_d;
  logic [3:0][DATA_W-1:0]  opb_q, opb_d;

  logic                    load_out_q, load_out_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       row0_q, row0_d;
  logic [DATA_W-1:0]       row1_q, row1_d;
  logic [DATA_W-1:0]       col0_q, col0_d;
  logic [DATA_W-1:0]       col1_q, col1_d;

  // Sequencer next state: operand capture, beat counting and interval timers
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gap_tmr_d   = gap_tmr_q;
    drain_tmr_d = drain_tmr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          opa_d   = {bus.a22, bus.a21, bus.a12, bus.a11};
          opb_d   = {bus.b22, bus.b21, bus.b12, bus.b11};
          beat_d  = 2'd0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (beat_q == 2'd3) begin
          state_d     = DRAIN;
          drain_tmr_d = DRAIN_RELOAD;
        end else begin
          state_d   = GAP;
          gap_tmr_d = GAP_RELOAD;
        end
      end
      GAP: begin
        if (gap_tmr_q == 8'd0) begin
          state_d = LOAD;
          beat_d  = beat_q + 2'd1;
        end else begin
          gap_tmr_d = gap_tmr_q - 8'd1;
        end
      end
      DRAIN: begin
        if (drain_tmr_q == 16'd0) begin
          state_d = DONE;
        end else begin
          drain_tmr_d = drain_tmr_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    row0_d     = row0_q;
    row1_d     = row1_q;
    col0_d     = col0_q;
    col1_d     = col1_q;
    load_out_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);

    case (state_d)
      LOAD: begin
        case (beat_d)
          2'd0: begin
            row0_d = opa_d[1];
            row1_d = '0;
            col0_d = opb_d[2];
            col1_d = '0;
          end
          2'd1: begin
            row0_d = opa_d[0];
            row1_d = opa_d[3];
            col0_d = opb_d[0];
            col1_d = opb_d[3];
          end
          2'd2: begin
            row0_d = '0;
            row1_d = opa_d[2];
            col0_d = '0;
            col1_d = opb_d[1];
          end
          default: begin
            row0_d = '0;
            row1_d = '0;
            col0_d = '0;
            col1_d = '0;
          end
        endcase
      end
      GAP: begin
        row0_d = row0_q;
        row1_d = row1_q;
        col0_d = col0_q;
        col1_d = col1_q;
      end
      default: begin
        row0_d = '0;
        row1_d = '0;
        col0_d = '0;
        col1_d = '0;
      end
    endcase
  end

  // State, operand and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      gap_tmr_q   <= 8'd0;
      drain_tmr_q <= 16'd0;
      opa_q       <= '0;
      opb_q       <= '0;
      load_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row0_q      <= '0;
      row1_q      <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_tmr_q   <= gap_tmr_d;
      drain_tmr_q <= drain_tmr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      load_out_q  <= load_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row0_q      <= row0_d;
      row1_q      <= row1_d;
      col0_q      <= col0_d;
      col1_q      <= col1_d;
    end
  end

  assign bus.load_out     = load_out_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.row_out_row0 = row0_q;
  assign bus.row_out_row1 = row1_q;
  assign bus.col_out_col0 = col0_q;
  assign bus.col_out_col1 = col1_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2: a default-parameter instance and a fast
// instance (BEAT_PERIOD=2, DRAIN_CYCLES=1) share reset and operands. A
// timeline model derives every output from the cycle offset since start.
module tb_systolic_feeder_2x2;

  localparam int DEF_BP = 16;
  localparam int DEF_DR = 100;
  localparam int DEF_L  = 1 + 3 * DEF_BP + DEF_DR + 1;
  localparam int FST_BP = 2;
  localparam int FST_DR = 1;
  localparam int FST_L  = 1 + 3 * FST_BP + FST_DR + 1;

  typedef struct packed {
    logic        load;
    logic        busy;
    logic        done;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] c0;
    logic [31:0] c1;
  } exp_t;

  logic clk;
  logic rst;
  logic sd;
  logic sf;
  logic [7:0][31:0] op_in;
  logic cmp_en;
  logic hold_fast;

  int n_cmp;
  int n_bad;

  int t_def;
  int t_fst;
  logic [7:0][31:0] ops_def;
  logic [7:0][31:0] ops_fst;

  int cyc;
  int prev_done;
  logic prev_ok;

  systolic_feeder_2x2_if #(.DATA_W(32)) bus_def ();
  systolic_feeder_2x2_if #(.DATA_W(32)) bus_fst ();

  assign bus_def.start = sd;
  assign bus_def.a11 = op_in[0];
  assign bus_def.a12 = op_in[1];
  assign bus_def.a21 = op_in[2];
  assign bus_def.a22 = op_in[3];
  assign bus_def.b11 = op_in[4];
  assign bus_def.b12 = op_in[5];
  assign bus_def.b21 = op_in[6];
  assign bus_def.b22 = op_in[7];

  assign bus_fst.start = sf;
  assign bus_fst.a11 = op_in[0];
  assign bus_fst.a12 = op_in[1];
  assign bus_fst.a21 = op_in[2];
  assign bus_fst.a22 = op_in[3];
  assign bus_fst.b11 = op_in[4];
  assign bus_fst.b12 = op_in[5];
  assign bus_fst.b21 = op_in[6];
  assign bus_fst.b22 = op_in[7];

  systolic_feeder_2x2 #(
    .DATA_W(32), .BEAT_PERIOD(DEF_BP), .DRAIN_CYCLES(DEF_DR)
  ) dut_def (
    .clk(clk), .rst(rst), .bus(bus_def)
  );

  systolic_feeder_2x2 #(
    .DATA_W(32), .BEAT_PERIOD(FST_BP), .DRAIN_CYCLES(FST_DR)
  ) dut_fst (
    .clk(clk), .rst(rst), .bus(bus_fst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0][31:0] mkOps(
    input logic [31:0] a11, input logic [31:0] a12,
    input logic [31:0] a21, input logic [31:0] a22,
    input logic [31:0] b11, input logic [31:0] b12,
    input logic [31:0] b21, input logic [31:0] b22);
    logic [7:0][31:0] v;
    v[0] = a11; v[1] = a12; v[2] = a21; v[3] = a22;
    v[4] = b11; v[5] = b12; v[6] = b21; v[7] = b22;
    return v;
  endfunction

  // Expected outputs at offset t (1 = first cycle after the start edge)
  function automatic exp_t modelOut(input int t, input int bp, input int dr,
                                    input logic [7:0][31:0] ops);
    exp_t e;
    int last_load;
    int total;
    int n;
    e = '0;
    last_load = 1 + 3 * bp;
    total = last_load + dr + 1;
    if (t > 0) begin
      e.busy = 1'b1;
      e.done = (t == total);
      if (t <= last_load) begin
        n = (t - 1) / bp;
        e.load = ((t - 1) % bp) == 0;
        case (n)
          0: begin e.r0 = ops[1]; e.c0 = ops[6]; end
          1: begin e.r0 = ops[0]; e.r1 = ops[3]; e.c0 = ops[4]; e.c1 = ops[7]; end
          2: begin e.r1 = ops[2]; e.c1 = ops[5]; end
          default: ;
        endcase
      end
    end
    return e;
  endfunction

  task automatic stepModel(input logic s, input int total,
                           inout int t, inout logic [7:0][31:0] ops);
    if (rst) begin
      t = 0;
    end else if ((t == 0 || t == total) && s) begin
      t = 1;
      ops = op_in;
    end else if (t == total) begin
      t = 0;
    end else if (t > 0) begin
      t = t + 1;
    end
  endtask

  // Model advances on the same edge that the DUTs sample
  always @(posedge clk) begin
    stepModel(sd, DEF_L, t_def, ops_def);
    stepModel(sf, FST_L, t_fst, ops_fst);
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareDef(input exp_t e);
    checkOutput("def.load_out", 32'(bus_def.load_out), 32'(e.load));
    checkOutput("def.busy", 32'(bus_def.busy), 32'(e.busy));
    checkOutput("def.done", 32'(bus_def.done), 32'(e.done));
    checkOutput("def.row0", bus_def.row_out_row0, e.r0);
    checkOutput("def.row1", bus_def.row_out_row1, e.r1);
    checkOutput("def.col0", bus_def.col_out_col0, e.c0);
    checkOutput("def.col1", bus_def.col_out_col1, e.c1);
  endtask

  task automatic compareFst(input exp_t e);
    checkOutput("fst.load_out", 32'(bus_fst.load_out), 32'(e.load));
    checkOutput("fst.busy", 32'(bus_fst.busy), 32'(e.busy));
    checkOutput("fst.done", 32'(bus_fst.done), 32'(e.done));
    checkOutput("fst.row0", bus_fst.row_out_row0, e.r0);
    checkOutput("fst.row1", bus_fst.row_out_row1, e.r1);
    checkOutput("fst.col0", bus_fst.col_out_col0, e.c0);
    checkOutput("fst.col1", bus_fst.col_out_col1, e.c1);
  endtask

  // Per-cycle comparison against the model, plus the fast done spacing
  always @(negedge clk) begin
    if (cmp_en) begin
      cyc++;
      compareDef(modelOut(t_def, DEF_BP, DEF_DR, ops_def));
      compareFst(modelOut(t_fst, FST_BP, FST_DR, ops_fst));
      if (!hold_fast || rst) begin
        prev_ok = 1'b0;
      end else if (bus_fst.done) begin
        if (prev_ok) checkOutput("fst.done_interval", 32'(cyc - prev_done), 32'd9);
        prev_done = cyc;
        prev_ok = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s_def, input logic s_fst,
                               input logic [7:0][31:0] ops);
    sd = s_def;
    sf = s_fst;
    op_in = ops;
  endtask

  task automatic checkLiteral(input string tag, input logic load, input logic busy,
                              input logic done, input logic [31:0] r0,
                              input logic [31:0] r1, input logic [31:0] c0,
                              input logic [31:0] c1);
    checkOutput({tag, ".load_out"}, 32'(bus_def.load_out), 32'(load));
    checkOutput({tag, ".busy"}, 32'(bus_def.busy), 32'(busy));
    checkOutput({tag, ".done"}, 32'(bus_def.done), 32'(done));
    checkOutput({tag, ".row0"}, bus_def.row_out_row0, r0);
    checkOutput({tag, ".row1"}, bus_def.row_out_row1, r1);
    checkOutput({tag, ".col0"}, bus_def.col_out_col0, c0);
    checkOutput({tag, ".col1"}, bus_def.col_out_col1, c1);
  endtask

  logic [7:0][31:0] m1234;
  logic [7:0][31:0] mffff;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    t_def = 0;
    t_fst = 0;
    ops_def = '0;
    ops_fst = '0;
    cyc = 0;
    prev_done = 0;
    prev_ok = 1'b0;
    cmp_en = 1'b0;
    hold_fast = 1'b0;
    rst = 1'b1;
    m1234 = mkOps(32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4);
    mffff = {8{32'hFFFF_FFFF}};
    applyStimulus(1'b0, 1'b0, '0);
    step();
    cmp_en = 1'b1;
    step();
    step();
    checkLiteral("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Start, then reset during the beat-1 gap
    $display("[TB] reset mid-sequence");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, m1234);
    hold_fast = 1'b1;
    step();
    sd = 1'b0;
    repeat (19) step();
    checkOutput("midseq.load_before_rst", 32'(bus_def.load_out), 32'd0);
    rst = 1'b1;
    step();
    checkLiteral("midrst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    rst = 1'b0;

    // Nominal run with operand isolation and an ignored start at k+20
    $display("[TB] nominal sequence");
    applyStimulus(1'b1, 1'b1, m1234);
    step();
    applyStimulus(1'b0, 1'b1, mffff);
    checkLiteral("beat0", 1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 32'd3, 32'd0);
    repeat (16) step();
    checkLiteral("beat1", 1'b1, 1'b1, 1'b0, 32'd1, 32'd4, 32'd1, 32'd4);
    repeat (3) step();
    applyStimulus(1'b1, 1'b1, mkOps(32'd4, 32'd2, 32'd1, 32'd8,
                                    32'd1, 32'd2, 32'd3, 32'd4));
    step();
    sd = 1'b0;
    repeat (12) step();
    checkLiteral("beat2", 1'b1, 1'b1, 1'b0, 32'd0, 32'd3, 32'd0, 32'd2);
    repeat (16) step();
    checkLiteral("beat3", 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (101) step();
    checkLiteral("done", 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    checkLiteral("after_done", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    // All-ones operands pass through bit-exact
    $display("[TB] max-value operands");
    applyStimulus(1'b1, 1'b1, mffff);
    step();
    applyStimulus(1'b0, 1'b1, m1234);
    checkLiteral("max_beat0", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0);
    repeat (16) step();
    checkLiteral("max_beat1", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (134) step();

    // Randomized starts, operands and occasional resets
    $display("[TB] randomized phase");
    hold_fast = 1'b0;
    for (int i = 0; i < 900; i++) begin
      logic [7:0][31:0] r;
      for (int j = 0; j < 8; j++) r[j] = $urandom;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, r);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (160) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
